wb_stage: RTL
=============

Name: wb_stage

Overview:
- Writeback stage that drives the register file's single write port.
- Sources: in-order pipeline results from the MEM stage, and out-of-order results from the long-latency divider.
- Formats load data, arbitrates the two sources (pipeline priority), buffers divider results in a small FIFO, suppresses x0 writes, and counts retired instructions.
- Outputs are registered and feed the register file write port and the EX-stage forwarding mux.

Parameters:
- WIDTH, 32, data width; load formatting requires 32.
- ADDR_WIDTH, 5, register address width.
- FIFO_DEPTH, 2, divider result FIFO entries; power of two, at least 2.
- CNT_WIDTH, 64, retired-instruction counter width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset; reset=0 resets on the rising clk edge
- pipe_valid  input  1  MEM-stage instruction present this cycle
- pipe_reg_write  input  1  instruction writes rd
- pipe_rd  input  ADDR_WIDTH  destination register
- pipe_wb_sel  input  2  source select: 00 ALU, 01 load, 10 PC+4, 11 ALU
- pipe_funct3  input  3  load type
- pipe_alu_result  input  WIDTH  ALU result / load address
- pipe_load_word  input  WIDTH  aligned 32-bit word read from data memory
- pipe_pc_plus4  input  WIDTH  link value
- div_valid  input  1  divider result offered
- div_ready  output  1  FIFO can accept; = !full
- div_rd  input  ADDR_WIDTH  divider destination
- div_result  input  WIDTH  divider result
- write_enable  output  1  register file write strobe
- write_addr  output  ADDR_WIDTH  register file write address
- write_data  output  WIDTH  register file write data
- instret  output  CNT_WIDTH  retired-instruction count
- fifo_empty  output  1  no pending divider writes; used by the hazard unit for drain

Behaviour:
- **Reset (reset=0 at a clk edge):**
  - write_enable=0, write_addr=0, write_data=0, instret=0.
  - FIFO pointers and count cleared, so fifo_empty=1 and div_ready=1.
  - Entries already queued are discarded.
  - Reset wins over every simultaneous event.
- **Pipe claim:** in cycle N the pipe claims the port when pipe_valid && pipe_reg_write && pipe_rd!=0.
  - write_enable=1, write_addr=pipe_rd, write_data=formatted value, all during cycle N+1.
  - Latency is exactly 1 cycle.
- **FIFO pop:** if the pipe does not claim in cycle N and the FIFO is non-empty, the head is popped.
  - Pop outputs appear in N+1 with write_enable = (head.rd != 0).
- **Idle:** with no claim and no pop, write_enable=0 in N+1. write_addr and write_data hold their previous values.
- **Priority:** the pipe always wins; the FIFO head waits.
  - Starvation is acceptable because the pipeline stalls on divider dependences.
- **Push:** div_valid && div_ready pushes at the edge ending cycle N.
  - A pushed entry is poppable from N+1, so the earliest write is N+2.
  - There is no bypass around the FIFO.
- **Full:** div_ready=0 whenever count==FIFO_DEPTH, even if a pop occurs the same cycle (no push-on-full).
  - The divider must hold div_valid, div_rd and div_result until accepted.
- **Simultaneous push and pop:** allowed when not full; count is unchanged.
- **Pointer wrap:** read and write pointers wrap modulo FIFO_DEPTH.
- **Load formatting** (wb_sel=01), with off = alu_result[1:0]:
  - funct3 000 (LB): byte at bit offset 8*off, sign-extended.
  - funct3 100 (LBU): byte at bit offset 8*off, zero-extended.
  - funct3 001 (LH): half at bit offset 16*off[1], sign-extended; off[0] is ignored.
  - funct3 101 (LHU): half at bit offset 16*off[1], zero-extended; off[0] is ignored.
  - funct3 010 and all other codes: full word.
- **Other sources:** wb_sel=10 writes pc_plus4; wb_sel 00 and 11 write alu_result.
- **x0 rule:** write_enable is never 1 with write_addr=0.
- **instret:**
  - Increments by 1 for each cycle with pipe_valid=1 (independent of reg_write or rd).
  - Increments by 1 for each FIFO pop, including rd=0 entries.
  - A pipe_valid cycle and a pop in the same cycle add 2.
  - Wraps modulo 2^CNT_WIDTH.

Test Plan:
- **ALU write:** reset=0 for 2 cycles, then pipe_valid=1, reg_write=1, rd=5, wb_sel=00, alu_result=32'hDEADBEEF → next cycle write_enable=1, write_addr=5, write_data=32'hDEADBEEF; instret=1.
- **Load formatting:** load_word=32'h80F1_7F22, wb_sel=01.
  - LB off=2 → 32'hFFFFFFF1.
  - LBU off=3 → 32'h00000080.
  - LH off=2 → 32'hFFFF80F1.
  - LHU off=0 → 32'h00007F22.
  - LW → 32'h80F17F22.
- **Arbitration:** push div rd=7, result=42 while the pipe writes rd=3 for 3 consecutive cycles.
  - rd=3 is written for 3 cycles; rd=7 = 42 is written in the first cycle after the pipe stops claiming.
- **FIFO full and wrap:** pipe continuously claiming, offer 3 div results (rd=1, 2, 3).
  - div_ready drops after 2 pushes; the third is held.
  - After the pipe stops, writes are rd=1, then 2, then 3 in order, across pointer wrap.
- **x0 suppression:** pipe rd=0 with reg_write=1 → write_enable stays 0, instret increments; a div entry with rd=0 pops with write_enable=0 and instret+1.
- **Reset mid-operation:** reset=0 asserted with 2 FIFO entries queued and instret=9 → next cycle write_enable=0, fifo_empty=1, div_ready=1, instret=0; no queued write ever appears.

Source files
------------

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : Writeback stage driving the register file's single write port.
//            It merges in-order MEM-stage results with out-of-order divider
//            results. The pipeline always has priority. Divider results wait
//            in a small FIFO until the port is free. Load data is extracted
//            and extended, writes to x0 are suppressed, and retired
//            instructions are counted.
// Ports    : clk, reset (sync, active-low)
//            pipe_*      MEM-stage result and writeback controls
//            div_*       divider result offer / FIFO ready handshake
//            write_*     registered register-file write port
//            instret     retired-instruction counter
//            fifo_empty  no divider writes pending
// Revision : 1.0  initial release
// ============================================================================
module wb_stage #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_WIDTH  = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pipe_valid,
   input  logic                  pipe_reg_write,
   input  logic [ADDR_WIDTH-1:0] pipe_rd,
   input  logic [1:0]            pipe_wb_sel,
   input  logic [2:0]            pipe_funct3,
   input  logic [WIDTH-1:0]      pipe_alu_result,
   input  logic [WIDTH-1:0]      pipe_load_word,
   input  logic [WIDTH-1:0]      pipe_pc_plus4,
   input  logic                  div_valid,
   output logic                  div_ready,
   input  logic [ADDR_WIDTH-1:0] div_rd,
   input  logic [WIDTH-1:0]      div_result,
   output logic                  write_enable,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic [WIDTH-1:0]      write_data,
   output logic [CNT_WIDTH-1:0]  instret,
   output logic                  fifo_empty
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   // Divider result FIFO storage and bookkeeping
   logic [ADDR_WIDTH-1:0] fifo_rd   [FIFO_DEPTH];
   logic [WIDTH-1:0]      fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [CNT_W-1:0]      count;

   logic                  claim;
   logic                  pop;
   logic                  push;
   logic [1:0]            retire_inc;

   // Load formatting
   logic [1:0]            off;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [WIDTH-1:0]      load_val;
   logic [WIDTH-1:0]      pipe_val;

   // Full is judged on the registered count only, so a same-cycle pop never
   // opens a slot for a push.
   assign div_ready  = (count != DEPTH_C);
   assign fifo_empty = (count == '0);

   assign claim = pipe_valid && pipe_reg_write && (pipe_rd != '0);
   assign pop   = !claim && !fifo_empty;
   assign push  = div_valid && div_ready;

   assign retire_inc = {1'b0, pipe_valid} + {1'b0, pop};

   assign off = pipe_alu_result[1:0];

   always_comb begin
      ld_byte = pipe_load_word[7:0];
      case (off)
         2'd0: ld_byte = pipe_load_word[7:0];
         2'd1: ld_byte = pipe_load_word[15:8];
         2'd2: ld_byte = pipe_load_word[23:16];
         2'd3: ld_byte = pipe_load_word[31:24];
         default: ld_byte = pipe_load_word[7:0];
      endcase
   end

   // Halfword selection ignores off[0]; misaligned halves are not split.
   assign ld_half = off[1] ? pipe_load_word[31:16] : pipe_load_word[15:0];

   always_comb begin
      load_val = pipe_load_word;
      case (pipe_funct3)
         3'b000:  load_val = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
         3'b100:  load_val = {{(WIDTH-8){1'b0}}, ld_byte};
         3'b001:  load_val = {{(WIDTH-16){ld_half[15]}}, ld_half};
         3'b101:  load_val = {{(WIDTH-16){1'b0}}, ld_half};
         default: load_val = pipe_load_word;
      endcase
   end

   always_comb begin
      pipe_val = pipe_alu_result;
      case (pipe_wb_sel)
         2'b01:   pipe_val = load_val;
         2'b10:   pipe_val = pipe_pc_plus4;
         default: pipe_val = pipe_alu_result;
      endcase
   end

   // FIFO storage has no reset; stale entries are unreachable once the
   // pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[wr_ptr]   <= div_rd;
         fifo_data[wr_ptr] <= div_result;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         write_enable <= 1'b0;
         write_addr   <= '0;
         write_data   <= '0;
         instret      <= '0;
      end else begin
         if (claim) begin
            write_enable <= 1'b1;
            write_addr   <= pipe_rd;
            write_data   <= pipe_val;
         end else if (pop) begin
            // An rd=0 entry still drains and retires, but never strobes.
            write_enable <= (fifo_rd[rd_ptr] != '0);
            write_addr   <= fifo_rd[rd_ptr];
            write_data   <= fifo_data[rd_ptr];
         end else begin
            write_enable <= 1'b0;
         end
         instret <= instret + CNT_WIDTH'(retire_inc);
      end
   end

endmodule
`default_nettype wire
